// File: rtl/mesh_term_pkg.sv
// mesh_term_pkg: shared definitions for the mesh terminal port.
//   - Header field offsets, measured down from the packet MSB.
//   - dest_match(): destination check used on the RX path.
//   - ERR_W: width of the error counter.
package mesh_term_pkg;

  localparam int ERR_W   = 16;
  localparam int ROW_W   = 4;
  localparam int COL_W   = 4;
  // Field MSB sits at pckg_sz - <OFS>. The 8-bit next-jump field above
  // the row is ignored by the terminal.
  localparam int ROW_OFS = 9;
  localparam int COL_OFS = 13;

  // A packet is ours if it carries our {row,col} or the broadcast code.
  function automatic logic dest_match(input logic [ROW_W-1:0] row,
                                      input logic [COL_W-1:0] col,
                                      input logic [ROW_W-1:0] id_row,
                                      input logic [COL_W-1:0] id_col,
                                      input logic [7:0]       bdcst);
    return ({row, col} == {id_row, id_col}) || ({row, col} == bdcst);
  endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// mesh_term_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk        clock
//   srst_i     synchronous active-high reset (empties the FIFO)
//   wr_en_i    write request; accepted when not full, or when full and a
//              read happens in the same cycle
//   wr_data_i  write data
//   rd_en_i    read (dequeue) request; ignored while empty
//   rd_data_o  head entry, forced to zero while empty
//   full_o     DEPTH entries stored
//   empty_o    no entries stored
module mesh_term_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         srst_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // One extra pointer bit separates the full and empty cases on wrap.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]  count_w;
  logic         do_wr, do_rd;

  assign count_w = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_w == (AW+1)'(DEPTH));
  assign empty_o = (count_w == '0);
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);

  // Zero while empty so the head never exposes stale storage.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/mesh_terminal_port.sv
// mesh_terminal_port: terminal-side endpoint of one mesh router port.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   tx_data/tx_valid/tx_ready       user -> TX FIFO write side
//   pndng/data_out/pop              TX FIFO head toward the router
//   pndng_i_in/data_out_i_in/popin  router -> RX FIFO accept handshake
//   rx_data/rx_valid/rx_ready       RX FIFO head toward the user
//   hdr_err                         pulse, cycle after a misaddressed accept
//   err_cnt                         saturating protocol + header error count
module mesh_terminal_port
  import mesh_term_pkg::*;
#(
  parameter int         ROWS       = 4,
  parameter int         COLUMS     = 4,
  parameter int         pckg_sz    = 32,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] bdcst      = {8{1'b1}},
  parameter logic [3:0] ID_ROW     = 4'd0,
  parameter logic [3:0] ID_COL     = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [pckg_sz-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               pndng,
  output logic [pckg_sz-1:0] data_out,
  input  logic               pop,
  input  logic               pndng_i_in,
  input  logic [pckg_sz-1:0] data_out_i_in,
  output logic               popin,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               hdr_err,
  output logic [ERR_W-1:0]   err_cnt
);

  if (pckg_sz < 17 || fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0 ||
      int'(ID_ROW) >= ROWS || int'(ID_COL) >= COLUMS) begin : g_bad_params
    $error("mesh_terminal_port: illegal parameter set");
  end

  logic               tx_full, tx_empty, tx_wr, tx_rd;
  logic               rx_full, rx_empty, rx_rd;
  logic [ROW_W-1:0]   rx_row;
  logic [COL_W-1:0]   rx_col;
  logic               prot_err, hdr_mis;
  logic [1:0]         err_inc;
  logic [ERR_W:0]     err_sum;
  logic               hdr_err_q, hdr_err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  // TX: user side writes only when there is room; overflow is silently dropped.
  assign tx_ready = !tx_full;
  assign tx_wr    = tx_valid && !tx_full;
  assign pndng    = !tx_empty;
  assign tx_rd    = pop && !tx_empty;
  assign prot_err = pop && tx_empty;

  // RX: accept is decided on the pre-read fill level, so a full FIFO being
  // drained this cycle still refuses the router (one-cycle bubble).
  assign popin    = pndng_i_in && !rx_full && !reset;
  assign rx_valid = !rx_empty;
  assign rx_rd    = rx_ready && !rx_empty;

  assign rx_row  = data_out_i_in[pckg_sz-ROW_OFS -: ROW_W];
  assign rx_col  = data_out_i_in[pckg_sz-COL_OFS -: COL_W];
  assign hdr_mis = popin && !dest_match(rx_row, rx_col, ID_ROW, ID_COL, bdcst);

  mesh_term_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_tx_fifo (
    .clk       (clk),
    .srst_i    (reset),
    .wr_en_i   (tx_wr),
    .wr_data_i (tx_data),
    .rd_en_i   (tx_rd),
    .rd_data_o (data_out),
    .full_o    (tx_full),
    .empty_o   (tx_empty)
  );

  // Misaddressed packets are still delivered; only flagged.
  mesh_term_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_rx_fifo (
    .clk       (clk),
    .srst_i    (reset),
    .wr_en_i   (popin),
    .wr_data_i (data_out_i_in),
    .rd_en_i   (rx_rd),
    .rd_data_o (rx_data),
    .full_o    (rx_full),
    .empty_o   (rx_empty)
  );

  // Both error sources in one cycle add 2; the extra sum bit detects overflow.
  always_comb begin
    err_inc   = {1'b0, prot_err} + {1'b0, hdr_mis};
    err_sum   = {1'b0, err_cnt_q} + (ERR_W+1)'(err_inc);
    err_cnt_d = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    hdr_err_d = hdr_mis;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      hdr_err_q <= hdr_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign hdr_err = hdr_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mesh_terminal_port.sv
module tb_mesh_terminal_port;

  localparam int W = 32;
  localparam int D = 4;
  localparam logic [3:0] IDR = 4'd2;
  localparam logic [3:0] IDC = 4'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         pndng;
  logic [W-1:0] data_out;
  logic         pop;
  logic         pndng_i_in;
  logic [W-1:0] data_out_i_in;
  logic         popin;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         hdr_err;
  logic [15:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queues plus an error tally.
  logic [W-1:0] m_tx[$];
  logic [W-1:0] m_rx[$];
  int           m_err;
  bit           m_hdr;

  always #5 clk = ~clk;

  mesh_terminal_port #(
    .ROWS(4), .COLUMS(4), .pckg_sz(W), .fifo_depth(D),
    .bdcst(8'hFF), .ID_ROW(IDR), .ID_COL(IDC)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pndng(pndng), .data_out(data_out), .pop(pop),
    .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .hdr_err(hdr_err), .err_cnt(err_cnt)
  );

  // Called at a negedge with inputs set: decides what the edge does from the
  // spec rules, waits through the posedge, applies it to the model.
  task automatic tick();
    int ts, rs;
    bit clr, do_tw, do_pop, prot, do_acc, do_rd, mis;
    logic [7:0] dest;
    logic [W-1:0] tdat, rdat, popped;
    ts = m_tx.size(); rs = m_rx.size();
    clr = reset;
    do_tw  = !clr && tx_valid && ts < D;
    do_pop = !clr && pop && ts > 0;
    prot   = !clr && pop && ts == 0;
    do_acc = !clr && pndng_i_in && rs < D;
    do_rd  = !clr && rx_ready && rs > 0;
    dest   = data_out_i_in[W-9 -: 8];
    mis    = do_acc && !(dest == {IDR, IDC} || dest == 8'hFF);
    tdat = tx_data; rdat = data_out_i_in;
    @(posedge clk);
    if (clr) begin
      m_tx.delete(); m_rx.delete(); m_err = 0; m_hdr = 0;
    end else begin
      if (do_pop) begin popped = m_tx.pop_front(); $display("tx pop  %h", popped); end
      if (do_tw) begin m_tx.push_back(tdat); $display("tx push %h", tdat); end
      if (do_rd) begin popped = m_rx.pop_front(); $display("rx read %h", popped); end
      if (do_acc) begin m_rx.push_back(rdat); $display("rx acc  %h mis=%0d", rdat, mis); end
      m_err = m_err + int'(prot) + int'(mis);
      if (m_err > 65535) m_err = 65535;
      m_hdr = mis;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; tx_valid = 0; tx_data = '0; pop = 0;
    pndng_i_in = 0; data_out_i_in = '0; rx_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; pndng_i_in = 1; data_out_i_in = 32'h00230001;
    tick(); #1;
    n_checks++;
    if (popin !== 1'b0) begin n_fail++; $display("FAIL reset_popin got %b want 0", popin); end
    n_checks++;
    if ({pndng, data_out, tx_ready, rx_valid, rx_data, hdr_err, err_cnt} !==
        {1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_state got pndng=%b dout=%h txr=%b rxv=%b rxd=%h he=%b ec=%h want 0,0,1,0,0,0,0",
               pndng, data_out, tx_ready, rx_valid, rx_data, hdr_err, err_cnt);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_tx_basic();
    do_reset();
    tx_valid = 1; tx_data = 32'hAA230001; tick(); tx_valid = 0; #1;
    n_checks++;
    if ({pndng, data_out} !== {1'b1, 32'hAA230001}) begin
      n_fail++; $display("FAIL tx_basic_head got %b/%h want 1/aa230001", pndng, data_out);
    end
    pop = 1; tick(); pop = 0; #1;
    n_checks++;
    if ({pndng, data_out} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL tx_basic_pop got %b/%h want 0/0", pndng, data_out);
    end
  endtask

  task automatic test_tx_full();
    do_reset();
    for (int i = 0; i < D; i++) begin
      tx_valid = 1; tx_data = 32'h10000000 + i; tick();
    end
    #1;
    n_checks++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_full_ready got %b want 0", tx_ready); end
    tx_data = 32'hDEADBEEF; tick(); tx_valid = 0;
    for (int i = 0; i < D; i++) begin
      pop = 1; #1;
      n_checks++;
      if ({pndng, data_out} !== {1'b1, 32'h10000000 + i}) begin
        n_fail++; $display("FAIL tx_full_order[%0d] got %b/%h want 1/%h", i, pndng, data_out, 32'h10000000 + i);
      end
      tick();
    end
    pop = 0; #1;
    n_checks++;
    if (pndng !== 1'b0) begin n_fail++; $display("FAIL tx_full_drained got pndng=%b want 0", pndng); end
  endtask

  task automatic test_rx_full();
    int pulses;
    do_reset();
    pulses = 0;
    pndng_i_in = 1; data_out_i_in = 32'h00230055; rx_ready = 0;
    for (int i = 0; i < 6; i++) begin
      #1; if (popin === 1'b1) pulses++;
      tick();
    end
    n_checks++;
    if (pulses != 4) begin n_fail++; $display("FAIL rx_full_pulses got %0d want 4", pulses); end
    rx_ready = 1; #1;
    n_checks++;
    if ({popin, rx_valid, rx_data} !== {1'b0, 1'b1, 32'h00230055}) begin
      n_fail++; $display("FAIL rx_full_bubble got popin=%b rxv=%b rxd=%h want 0,1,00230055", popin, rx_valid, rx_data);
    end
    tick(); rx_ready = 0; #1;
    n_checks++;
    if (popin !== 1'b1) begin n_fail++; $display("FAIL rx_full_reenable got popin=%b want 1", popin); end
    tick(); pndng_i_in = 0;
  endtask

  task automatic test_hdr();
    do_reset();
    pndng_i_in = 1; data_out_i_in = 32'h00FF0000; tick();
    data_out_i_in = 32'h00110000; #1;
    n_checks++;
    if (hdr_err !== 1'b0) begin n_fail++; $display("FAIL hdr_bcast got hdr_err=%b want 0", hdr_err); end
    tick(); pndng_i_in = 0; #1;
    n_checks++;
    if ({hdr_err, err_cnt} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL hdr_mismatch got hdr_err=%b err_cnt=%0d want 1,1", hdr_err, err_cnt);
    end
    tick(); #1;
    n_checks++;
    if ({hdr_err, rx_data} !== {1'b0, 32'h00FF0000}) begin
      n_fail++; $display("FAIL hdr_pulse_end got hdr_err=%b rxd=%h want 0,00ff0000", hdr_err, rx_data);
    end
  endtask

  task automatic test_prot_err();
    do_reset();
    pop = 1; tick(); pop = 0; #1;
    n_checks++;
    if ({err_cnt, pndng, tx_ready} !== {16'd1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL prot_err got err_cnt=%0d pndng=%b txr=%b want 1,0,1", err_cnt, pndng, tx_ready);
    end
    tx_valid = 1; tx_data = 32'h12345678; tick(); tx_valid = 0; #1;
    n_checks++;
    if ({pndng, data_out} !== {1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL prot_err_after got %b/%h want 1/12345678", pndng, data_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1; tx_data = 32'h30000000 + i;
      pndng_i_in = (i < 2); data_out_i_in = 32'h00230000 + i;
      tick();
    end
    idle_inputs(); pop = 0;
    tx_valid = 0;
    // Force a nonzero error count before the reset: one misaddressed accept.
    pndng_i_in = 1; data_out_i_in = 32'h00440000; tick(); pndng_i_in = 0; #1;
    n_checks++;
    if ({err_cnt, rx_valid, pndng} !== {16'd1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid_pre got ec=%0d rxv=%b pndng=%b want 1,1,1", err_cnt, rx_valid, pndng);
    end
    reset = 1; tick(); reset = 0; #1;
    n_checks++;
    if ({pndng, data_out, tx_ready, popin, rx_valid, rx_data, hdr_err, err_cnt} !==
        {1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_post got pndng=%b dout=%h txr=%b popin=%b rxv=%b rxd=%h he=%b ec=%h want all reset values",
               pndng, data_out, tx_ready, popin, rx_valid, rx_data, hdr_err, err_cnt);
    end
  endtask

  task automatic test_random();
    logic [84:0] exp_v, got_v;
    logic [7:0] dest;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tx_valid = ($urandom_range(0, 1) == 1);
      tx_data  = $urandom;
      pop      = ($urandom_range(0, 2) != 0);
      pndng_i_in = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0: dest = {IDR, IDC};
        1: dest = 8'hFF;
        default: dest = 8'($urandom);
      endcase
      data_out_i_in = {8'($urandom), dest, 16'($urandom)};
      rx_ready = ($urandom_range(0, 1) == 1);
      #1;
      exp_v = {m_tx.size() != 0, (m_tx.size() != 0) ? m_tx[0] : 32'h0, m_tx.size() < D,
               pndng_i_in && (m_rx.size() < D),
               m_rx.size() != 0, (m_rx.size() != 0) ? m_rx[0] : 32'h0, m_hdr, 16'(m_err)};
      got_v = {pndng, data_out, tx_ready, popin, rx_valid, rx_data, hdr_err, err_cnt};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL random[%0d] got %h want %h", i, got_v, exp_v);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    m_err = 0; m_hdr = 0;
    idle_inputs();
    reset = 1;
    @(negedge clk);
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_full();
    test_hdr();
    test_prot_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mesh_terminal_port.md
# mesh_terminal_port

Terminal-side endpoint that attaches one user/agent port to one router port of the mesh. It is the counterpart of the router's terminal handshake. On TX, it buffers user packets and presents them to the router as `pndng`/`data_out`, dequeuing on the router's `pop`. On RX, it accepts router packets on `pndng_i_in`/`data_out_i_in`, acknowledges them with `popin`, checks the destination header, and buffers them for the user.

## Interface
- `ROWS`, default 4: mesh rows.
- `COLUMS`, default 4: mesh columns.
- `pckg_sz`, default 32: packet width in bits; minimum 17.
- `fifo_depth`, default 4: entries per FIFO (TX and RX); power of 2, ≥2.
- `bdcst`, default `{8{1'b1}}`: broadcast destination `{row,col}` code.
- `ID_ROW`, default 0: this terminal's row address (4 bits).
- `ID_COL`, default 0: this terminal's column address (4 bits).

Ports:
- `clk` in 1: clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `tx_data` in pckg_sz: user packet to send.
- `tx_valid` in 1: user write request.
- `tx_ready` out 1: TX FIFO not full.
- `pndng` out 1: TX packet pending toward router.
- `data_out` out pckg_sz: TX head packet.
- `pop` in 1: router consumes `data_out` this cycle.
- `pndng_i_in` in 1: router has packet for terminal.
- `data_out_i_in` in pckg_sz: router packet.
- `popin` out 1: terminal accepts `data_out_i_in` this cycle.
- `rx_data` out pckg_sz: RX head packet.
- `rx_valid` out 1: RX FIFO not empty.
- `rx_ready` in 1: user reads RX head this cycle.
- `hdr_err` out 1: one-cycle pulse when an accepted packet's destination mismatches.
- `err_cnt` out 16: saturating count of protocol and header errors.

## Operation
- Packet header: `[pckg_sz-1 -: 8]` is next-jump (ignored), `[pckg_sz-9 -: 4]` is dest row, `[pckg_sz-13 -: 4]` is dest col, `[pckg_sz-17]` is mode; the remainder is payload.
- TX write: `tx_valid && tx_ready` enqueues `tx_data`. `tx_valid` while full is dropped; `err_cnt` is not incremented.
- TX present: `pndng` = TX not empty; `data_out` = TX head, held stable until `pop`.
- TX dequeue: `pop && pndng` dequeues. `pop` while `!pndng` is ignored and increments `err_cnt`.
- RX accept: `popin` = `pndng_i_in && !rx_full && !reset` (combinational). On that edge `data_out_i_in` is enqueued.
- RX full: `popin` is held low. The router keeps data stable; no loss.
- Header check on accept: a packet matches if `{row,col}=={ID_ROW,ID_COL}` or `{row,col}==bdcst`. A mismatch is still enqueued, and raises `hdr_err` plus increments `err_cnt`.
- RX read: `rx_valid && rx_ready` dequeues.
- Simultaneous enqueue and dequeue on a full TX or RX FIFO are both allowed; the count is unchanged.
- `err_cnt` saturates at 16'hFFFF. A protocol error and a header error in the same cycle add 2.

## Timing
- Reset values: `pndng`=0, `data_out`=0, `popin`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `hdr_err`=0, `err_cnt`=0. Both FIFOs are emptied. Reset mid-transfer discards all contents.
- TX latency: write at edge t → `pndng`=1 and `data_out` valid after edge t (cycle t+1).
- `pop` at edge t → next head, or `pndng`=0, after edge t. Back-to-back pops give one packet per cycle.
- RX: `popin` is asserted in the same cycle `pndng_i_in` is seen with space. The packet is captured at that edge. `rx_valid` is set after the edge. `hdr_err` pulses in the cycle after the capture.
- RX full with `rx_ready` in the same cycle: `popin` stays 0 that cycle (full is evaluated before the read). There is a one-cycle bubble.
- Throughput: one packet per cycle per direction.

## Structure
- Package `mesh_term_pkg`: header field offsets, `dest_match()` function, `ERR_W=16`.
- Sub-module `mesh_term_fifo`: synchronous FIFO with `full`/`empty`/count, first-word-fall-through, and `fifo_depth`-entry circular buffer with wrap-around pointers. It is instantiated twice, once for TX and once for RX.
- Top level contains handshake glue, the header checker, and the error counter.

## Test plan
- Reset, then write 0xAA230001 with ID 2/3 → `pndng`=1 and `data_out`=0xAA230001 after the next edge. `pop` → `pndng`=0.
- Write 4 packets with no `pop` → `tx_ready`=0. A 5th write is dropped. 4 pops return packets in order, then `pndng`=0.
- `pndng_i_in`=1 with 0x00230055 held 6 cycles, `rx_ready`=0, depth 4 → 4 `popin` pulses, then `popin`=0 while full. Draining one packet re-enables `popin`.
- Accept 0x00FF0000 (broadcast) and 0x00110000 at ID 2/3 → `hdr_err` pulses only for the second; `err_cnt`=1.
- `pop` asserted while `pndng`=0 → `err_cnt` increments by 1 and FIFO state is unchanged.
- `reset` pulsed with 3 TX and 2 RX entries → all outputs return to reset values the next cycle; `err_cnt`=0.
